// File: rtl/prf_read_sched_pkg.sv
// Shared types and defaults for the PRF exec read-port scheduler.
package prf_read_sched_pkg;

    localparam int PRF_PREG_W  = 6;
    localparam int PRF_DATA_W  = 32;
    localparam int NUM_CLASSES = 3;

    // One requester's operand-read request.
    typedef struct packed {
        logic                  req;
        logic                  urgent;
        logic [PRF_PREG_W-1:0] rs1;
        logic [PRF_PREG_W-1:0] rs2;
    } prf_rd_req_t;

    // Scan order of the priority classes: lower value is served first.
    typedef enum logic [1:0] {
        CLS_STARVED = 2'd0,
        CLS_URGENT  = 2'd1,
        CLS_NORMAL  = 2'd2
    } prf_cls_e;

    // Index width that stays at least one bit for single-entry ranges.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prf_read_sched_rr_class_picker.sv
// Round-robin picker for one priority class: grants requesters starting at
// rr_ptr while ports remain, assigning consecutive port numbers from used_in.
module rr_class_picker #(
    parameter int N      = 3,
    parameter int P      = 2,
    parameter int PTR_W  = 2,
    parameter int PORT_W = 1,
    parameter int USED_W = 2
) (
    input  logic [N-1:0]             mask,
    input  logic [PTR_W-1:0]         rr_ptr,
    input  logic [USED_W-1:0]        used_in,
    output logic [N-1:0]             grant,
    output logic [N-1:0][PORT_W-1:0] port,
    output logic                     last_vld,
    output logic [PTR_W-1:0]         last_idx
);

    logic [USED_W-1:0] used;
    logic [PTR_W:0]    idx;

    always_comb begin
        grant    = '0;
        port     = '0;
        last_vld = 1'b0;
        last_idx = '0;
        used     = used_in;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            // rr_ptr < N, so a single subtraction wraps the scan index
            idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (idx >= (PTR_W+1)'(N)) begin
                idx = idx - (PTR_W+1)'(N);
            end
            if (mask[idx[PTR_W-1:0]] && (used < USED_W'(P))) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                port[idx[PTR_W-1:0]]  = PORT_W'(used);
                used                  = used + USED_W'(1);
                last_vld              = 1'b1;
                last_idx              = idx[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/prf_read_sched.sv
// PRF exec read-port scheduler: three-class round-robin arbitration of
// NUM_EXEC_UNITS requesters onto NUM_READ_PORTS two-operand read ports.
module prf_read_sched
    import prf_read_sched_pkg::*;
#(
    parameter int NUM_EXEC_UNITS = 3,
    parameter int NUM_READ_PORTS = 2,
    parameter int PREG_W         = PRF_PREG_W,
    parameter int DATA_W         = PRF_DATA_W,
    parameter int READ_LATENCY   = 1,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   exec_req      [NUM_EXEC_UNITS],
    input  logic                                   exec_urgent   [NUM_EXEC_UNITS],
    input  logic [PREG_W-1:0]                      exec_rs1_preg [NUM_EXEC_UNITS],
    input  logic [PREG_W-1:0]                      exec_rs2_preg [NUM_EXEC_UNITS],
    output logic                                   exec_grant    [NUM_EXEC_UNITS],
    output logic [PREG_W-1:0]                      prf_exec_preg [NUM_READ_PORTS][2],
    input  logic [DATA_W-1:0]                      prf_exec_data [NUM_READ_PORTS][2],
    output logic                                   exec_rdata_valid [NUM_EXEC_UNITS],
    output logic [DATA_W-1:0]                      exec_rs1_data [NUM_EXEC_UNITS],
    output logic [DATA_W-1:0]                      exec_rs2_data [NUM_EXEC_UNITS],
    output logic [idx_width(NUM_EXEC_UNITS)-1:0]   rr_ptr_o
);

    localparam int N      = NUM_EXEC_UNITS;
    localparam int P      = NUM_READ_PORTS;
    localparam int PTR_W  = idx_width(N);
    localparam int PORT_W = idx_width(P);
    localparam int USED_W = $clog2(P + 1);
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

    logic [PTR_W-1:0]                        rr_ptr_reg, rr_ptr_next;
    logic [CNT_W-1:0]                        wait_cnt_reg [N];
    logic                                    active;
    logic [NUM_CLASSES-1:0][N-1:0]           cls_mask;
    logic [NUM_CLASSES-1:0][USED_W-1:0]      used_in;
    logic [NUM_CLASSES-1:0][N-1:0]           pick_grant;
    logic [NUM_CLASSES-1:0][N-1:0][PORT_W-1:0] pick_port;
    logic [NUM_CLASSES-1:0]                  last_vld;
    logic [NUM_CLASSES-1:0][PTR_W-1:0]       last_idx;
    logic [N-1:0]                            grant;
    logic [N-1:0][PORT_W-1:0]                port_of;
    logic [N-1:0]                            rd_valid;
    logic [N-1:0][PORT_W-1:0]                rd_port;

    // Gating on rst keeps grants and port pregs at 0 while reset is held.
    assign active = !rst && !flush;

    always_comb begin
        cls_mask = '0;
        for (int u = 0; u < N; u++) begin
            if (active && exec_req[u]) begin
                if (wait_cnt_reg[u] == CNT_W'(STARVE_LIMIT)) begin
                    cls_mask[CLS_STARVED][u] = 1'b1;
                end else if (exec_urgent[u]) begin
                    cls_mask[CLS_URGENT][u] = 1'b1;
                end else begin
                    cls_mask[CLS_NORMAL][u] = 1'b1;
                end
            end
        end
    end

    // Ports consumed by higher classes equal their clamped request counts,
    // which avoids a combinational chain through the pickers themselves.
    always_comb begin
        int taken;
        taken   = 0;
        used_in = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            used_in[c] = USED_W'((taken > P) ? P : taken);
            taken      = taken + $countones(cls_mask[c]);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_cls
            rr_class_picker #(
                .N      (N),
                .P      (P),
                .PTR_W  (PTR_W),
                .PORT_W (PORT_W),
                .USED_W (USED_W)
            ) u_pick (
                .mask     (cls_mask[gi]),
                .rr_ptr   (rr_ptr_reg),
                .used_in  (used_in[gi]),
                .grant    (pick_grant[gi]),
                .port     (pick_port[gi]),
                .last_vld (last_vld[gi]),
                .last_idx (last_idx[gi])
            );
        end
    endgenerate

    // Later classes are scanned later, so their last grant sets the pointer.
    always_comb begin
        grant       = '0;
        port_of     = '0;
        rr_ptr_next = rr_ptr_reg;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            grant   = grant | pick_grant[c];
            port_of = port_of | pick_port[c];
            if (last_vld[c]) begin
                rr_ptr_next = (last_idx[c] == PTR_W'(N - 1)) ? '0 : last_idx[c] + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_wait
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    wait_cnt_reg[gi] <= '0;
                end else if (exec_req[gi] && !grant[gi] && !flush) begin
                    if (wait_cnt_reg[gi] != CNT_W'(STARVE_LIMIT)) begin
                        wait_cnt_reg[gi] <= wait_cnt_reg[gi] + CNT_W'(1);
                    end
                end else begin
                    wait_cnt_reg[gi] <= '0;
                end
            end
        end
    endgenerate

    generate
        if (READ_LATENCY == 0) begin : g_lat0
            assign rd_valid = grant;
            assign rd_port  = port_of;
        end else begin : g_lat1
            logic [N-1:0]             valid_reg;
            logic [N-1:0][PORT_W-1:0] port_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= '0;
                    port_reg  <= '0;
                end else begin
                    valid_reg <= flush ? '0 : grant;
                    port_reg  <= port_of;
                end
            end

            assign rd_valid = valid_reg;
            assign rd_port  = port_reg;
        end
    endgenerate

    always_comb begin
        for (int p = 0; p < P; p++) begin
            prf_exec_preg[p][0] = '0;
            prf_exec_preg[p][1] = '0;
        end
        for (int u = 0; u < N; u++) begin
            if (grant[u]) begin
                prf_exec_preg[port_of[u]][0] = exec_rs1_preg[u];
                prf_exec_preg[port_of[u]][1] = exec_rs2_preg[u];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_out
            assign exec_grant[gi]       = grant[gi];
            assign exec_rdata_valid[gi] = rd_valid[gi];
            assign exec_rs1_data[gi]    = rd_valid[gi] ? prf_exec_data[rd_port[gi]][0] : '0;
            assign exec_rs2_data[gi]    = rd_valid[gi] ? prf_exec_data[rd_port[gi]][1] : '0;
        end
    endgenerate

    assign rr_ptr_o = rr_ptr_reg;

endmodule

// File: tb/tb_prf_read_sched.sv
// Bench for prf_read_sched: a latency-0 and a latency-1 instance share stimulus
// and are compared every cycle against a queue-based arbitration model.
module tb_prf_read_sched;
    import prf_read_sched_pkg::*;

    localparam int N  = 3;
    localparam int P  = 2;
    localparam int PW = 6;
    localparam int DW = 32;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    logic          exec_req    [N];
    logic          exec_urgent [N];
    logic [PW-1:0] rs1 [N];
    logic [PW-1:0] rs2 [N];
    logic [DW-1:0] prf_data [P][2];

    logic          g0 [N], g1 [N];
    logic [PW-1:0] preg0 [P][2], preg1 [P][2];
    logic          v0 [N], v1 [N];
    logic [DW-1:0] a0 [N], b0 [N], a1 [N], b1 [N];
    logic [1:0]    rr0, rr1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    prf_read_sched #(.NUM_EXEC_UNITS(N), .NUM_READ_PORTS(P), .PREG_W(PW), .DATA_W(DW),
                     .READ_LATENCY(0), .STARVE_LIMIT(SL)) u_dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .exec_req(exec_req), .exec_urgent(exec_urgent),
        .exec_rs1_preg(rs1), .exec_rs2_preg(rs2),
        .exec_grant(g0), .prf_exec_preg(preg0), .prf_exec_data(prf_data),
        .exec_rdata_valid(v0), .exec_rs1_data(a0), .exec_rs2_data(b0),
        .rr_ptr_o(rr0)
    );

    prf_read_sched #(.NUM_EXEC_UNITS(N), .NUM_READ_PORTS(P), .PREG_W(PW), .DATA_W(DW),
                     .READ_LATENCY(1), .STARVE_LIMIT(SL)) u_dut1 (
        .clk(clk), .rst(rst), .flush(flush),
        .exec_req(exec_req), .exec_urgent(exec_urgent),
        .exec_rs1_preg(rs1), .exec_rs2_preg(rs2),
        .exec_grant(g1), .prf_exec_preg(preg1), .prf_exec_data(prf_data),
        .exec_rdata_valid(v1), .exec_rs1_data(a1), .exec_rs2_data(b1),
        .rr_ptr_o(rr1)
    );

    // Reference model state
    int m_rr;
    int m_cnt  [N];
    bit m_v    [N];
    int m_port [N];
    bit e_g    [N];
    int e_port [N];
    int e_rr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int class_of(int u);
        if (m_cnt[u] == SL) return 0;
        if (exec_urgent[u]) return 1;
        return 2;
    endfunction

    task automatic model_reset();
        m_rr = 0;
        for (int u = 0; u < N; u++) begin
            m_cnt[u] = 0; m_v[u] = 0; m_port[u] = 0;
        end
    endtask

    task automatic model_comb();
        int order[$];
        e_rr = m_rr;
        for (int u = 0; u < N; u++) begin
            e_g[u] = 0; e_port[u] = 0;
        end
        if (!flush) begin
            for (int c = 0; c < 3; c++) begin
                for (int k = 0; k < N; k++) begin
                    int u = (m_rr + k) % N;
                    if (exec_req[u] && class_of(u) == c) order.push_back(u);
                end
            end
        end
        for (int i = 0; i < order.size() && i < P; i++) begin
            e_g[order[i]]    = 1;
            e_port[order[i]] = i;
            e_rr             = (order[i] + 1) % N;
        end
    endtask

    task automatic model_seq();
        for (int u = 0; u < N; u++) begin
            if (exec_req[u] && !e_g[u] && !flush) m_cnt[u] = (m_cnt[u] < SL) ? m_cnt[u] + 1 : SL;
            else m_cnt[u] = 0;
            m_v[u]    = flush ? 1'b0 : e_g[u];
            m_port[u] = e_port[u];
        end
        m_rr = e_rr;
    endtask

    task automatic check_model();
        logic [PW-1:0] ep [P][2];
        logic [DW-1:0] ea, eb;
        for (int p = 0; p < P; p++) begin
            ep[p][0] = '0; ep[p][1] = '0;
        end
        for (int u = 0; u < N; u++) begin
            check($sformatf("grant_l0[%0d]", u), g0[u], e_g[u]);
            check($sformatf("grant_l1[%0d]", u), g1[u], e_g[u]);
            if (e_g[u]) begin
                ep[e_port[u]][0] = rs1[u];
                ep[e_port[u]][1] = rs2[u];
            end
            ea = e_g[u] ? prf_data[e_port[u]][0] : '0;
            eb = e_g[u] ? prf_data[e_port[u]][1] : '0;
            check($sformatf("valid_l0[%0d]", u), v0[u], e_g[u]);
            check($sformatf("rs1_l0[%0d]", u), a0[u], ea);
            check($sformatf("rs2_l0[%0d]", u), b0[u], eb);
            ea = m_v[u] ? prf_data[m_port[u]][0] : '0;
            eb = m_v[u] ? prf_data[m_port[u]][1] : '0;
            check($sformatf("valid_l1[%0d]", u), v1[u], m_v[u]);
            check($sformatf("rs1_l1[%0d]", u), a1[u], ea);
            check($sformatf("rs2_l1[%0d]", u), b1[u], eb);
        end
        for (int p = 0; p < P; p++) begin
            for (int o = 0; o < 2; o++) begin
                check($sformatf("preg_l0[%0d][%0d]", p, o), preg0[p][o], ep[p][o]);
                check($sformatf("preg_l1[%0d][%0d]", p, o), preg1[p][o], ep[p][o]);
            end
        end
        check("rr_l0", rr0, m_rr);
        check("rr_l1", rr1, m_rr);
    endtask

    task automatic check_zero(input string tag);
        for (int u = 0; u < N; u++) begin
            check({tag, "_grant"}, {g0[u], g1[u]}, 2'b00);
            check({tag, "_valid"}, {v0[u], v1[u]}, 2'b00);
            check({tag, "_data"}, {a0[u], b0[u], a1[u], b1[u]}, 64'd0);
        end
        for (int p = 0; p < P; p++) begin
            check({tag, "_preg"}, {preg0[p][0], preg0[p][1], preg1[p][0], preg1[p][1]}, 24'd0);
        end
        check({tag, "_rr"}, {rr0, rr1}, 4'd0);
    endtask

    // Called at a falling edge with inputs already applied.
    task automatic settle();
        #1;
        model_comb();
        check_model();
        $display("cyc=%0d flush=%0b req=%0b%0b%0b urg=%0b%0b%0b grant=%0b%0b%0b valid_l1=%0b%0b%0b rr=%0d",
                 cyc, flush, exec_req[2], exec_req[1], exec_req[0],
                 exec_urgent[2], exec_urgent[1], exec_urgent[0],
                 g0[2], g0[1], g0[0], v1[2], v1[1], v1[0], rr0);
    endtask

    task automatic advance();
        @(posedge clk);
        model_seq();
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_all(input bit rq, input bit ug);
        for (int u = 0; u < N; u++) begin
            exec_req[u] = rq; exec_urgent[u] = ug;
            rs1[u] = PW'(u + 1); rs2[u] = PW'(u + 17);
        end
    endtask

    function automatic logic [2:0] gvec();
        return {g0[2], g0[1], g0[0]};
    endfunction

    initial begin
        logic [1:0] rr_save;
        rst = 1'b1;
        flush = 1'b0;
        set_all(0, 0);
        for (int p = 0; p < P; p++) begin
            prf_data[p][0] = $urandom(); prf_data[p][1] = $urandom();
        end
        model_reset();
        repeat (2) @(negedge clk);
        #1 check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // All requesting, no urgency: rotating pairs from reset
        set_all(1, 0);
        settle(); check("rr_seq_g0", gvec(), 3'b011); advance(); check("rr_seq_p0", rr0, 2'd2);
        settle(); check("rr_seq_g1", gvec(), 3'b101); advance(); check("rr_seq_p1", rr0, 2'd1);
        settle(); check("rr_seq_g2", gvec(), 3'b110); advance(); check("rr_seq_p2", rr0, 2'd0);

        // Idle cycles
        set_all(0, 0);
        repeat (3) begin
            settle(); check("idle_grant", gvec(), 3'b000); advance();
        end

        // Starvation: units 0,1 urgent, unit 2 normal
        set_all(1, 1);
        exec_urgent[2] = 1'b0;
        rs1[2] = 6'd33;
        for (int i = 0; i < 4; i++) begin
            settle(); check("starve_denied", g0[2], 1'b0); advance();
        end
        settle();
        check("starve_grant", g0[2], 1'b1);
        check("starve_port0", preg0[0][0], 6'd33);
        advance();

        // Single late-latency read for unit 2
        set_all(0, 0);
        exec_req[2] = 1'b1; rs1[2] = 6'd5; rs2[2] = 6'd9;
        settle();
        check("single_port0", {preg1[0][0], preg1[0][1]}, {6'd5, 6'd9});
        check("single_port1", {preg1[1][0], preg1[1][1]}, 12'd0);
        advance();
        exec_req[2] = 1'b0;
        prf_data[0][0] = 32'hAAAA; prf_data[0][1] = 32'hBBBB;
        settle();
        check("single_valid", v1[2], 1'b1);
        check("single_rs1", a1[2], 32'hAAAA);
        check("single_rs2", b1[2], 32'hBBBB);
        advance();
        settle(); check("single_once", v1[2], 1'b0); advance();

        // Flush kills in-flight reads and blocks grants
        set_all(0, 0);
        exec_req[0] = 1'b1; exec_req[1] = 1'b1;
        settle(); advance();
        flush = 1'b1;
        settle();
        check("flush_valid_prev", {v1[1], v1[0]}, 2'b11);
        check("flush_no_grant", gvec(), 3'b000);
        rr_save = rr0;
        advance();
        flush = 1'b0;
        set_all(0, 0);
        settle();
        check("flush_valid_after", {v1[2], v1[1], v1[0]}, 3'b000);
        check("flush_rr_kept", rr0, rr_save);
        advance();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            flush = ($urandom_range(0, 9) == 0);
            for (int u = 0; u < N; u++) begin
                exec_req[u]    = ($urandom_range(0, 9) < 7);
                exec_urgent[u] = ($urandom_range(0, 9) < 3);
                rs1[u] = PW'($urandom()); rs2[u] = PW'($urandom());
            end
            for (int p = 0; p < P; p++) begin
                prf_data[p][0] = $urandom(); prf_data[p][1] = $urandom();
            end
            settle(); advance();
        end

        // Asynchronous reset between edges with reads in flight
        flush = 1'b0;
        set_all(1, 0);
        prf_data[0][0] = 32'h1234; prf_data[0][1] = 32'h5678;
        prf_data[1][0] = 32'h9ABC; prf_data[1][1] = 32'hDEF0;
        settle(); advance();
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        settle();
        check("post_rst_grant", gvec(), 3'b011);
        check("post_rst_rr", rr0, 2'd0);
        advance();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
